// File: rtl/sdram_arbiter.sv
// SDRAM request arbiter: one download write buffer plus four read ports share a
// single SDRAM controller request channel, with at most one transaction in flight.
//
// Ports:
//   clk, reset                      system clock, asynchronous active-high reset
//   dl_addr, dl_data, dl_wr         download write (absolute address, data, strobe)
//   dl_ready, dl_overflow           buffer empty flag, sticky dropped-write flag
//   pN_req, pN_addr (N=0..3)        read request level and segment-relative address
//   pN_ack, pN_valid, pN_q          accept pulse, read-data pulse, held read data
//   sdram_addr/data/we/req          request to the controller (held until ack)
//   sdram_ack, sdram_valid, sdram_q controller accept pulse, read-data pulse, data
module sdram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 23,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_0 = '0,
  parameter logic [ADDR_WIDTH-1:0] BASE_1 = '0,
  parameter logic [ADDR_WIDTH-1:0] BASE_2 = '0,
  parameter logic [ADDR_WIDTH-1:0] BASE_3 = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] dl_addr,
  input  logic [DATA_WIDTH-1:0] dl_data,
  input  logic                  dl_wr,
  output logic                  dl_ready,
  output logic                  dl_overflow,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_ack,
  output logic                  p0_valid,
  output logic [DATA_WIDTH-1:0] p0_q,
  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic                  p1_ack,
  output logic                  p1_valid,
  output logic [DATA_WIDTH-1:0] p1_q,
  input  logic                  p2_req,
  input  logic [ADDR_WIDTH-1:0] p2_addr,
  output logic                  p2_ack,
  output logic                  p2_valid,
  output logic [DATA_WIDTH-1:0] p2_q,
  input  logic                  p3_req,
  input  logic [ADDR_WIDTH-1:0] p3_addr,
  output logic                  p3_ack,
  output logic                  p3_valid,
  output logic [DATA_WIDTH-1:0] p3_q,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [DATA_WIDTH-1:0] sdram_data,
  output logic                  sdram_we,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  input  logic                  sdram_valid,
  input  logic [DATA_WIDTH-1:0] sdram_q
);

  typedef enum logic [1:0] {StIdle, StWaitAck, StWaitValid} state_e;

  state_e                state_q, state_d;
  logic [1:0]            rr_q, rr_d;        // first port examined on the next search
  logic [1:0]            owner_q, owner_d;  // read port owning the transaction
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            p_ack_q, p_ack_d;
  logic [3:0]            p_valid_q, p_valid_d;
  logic [DATA_WIDTH-1:0] p_q_q [4];
  logic [DATA_WIDTH-1:0] p_q_d [4];
  logic                  dl_full_q, dl_full_d;
  logic                  dl_ovf_q, dl_ovf_d;
  logic [ADDR_WIDTH-1:0] dl_addr_q, dl_addr_d;
  logic [DATA_WIDTH-1:0] dl_data_q, dl_data_d;

  logic [3:0]            p_req;
  logic [ADDR_WIDTH-1:0] p_addr [4];
  logic                  grant_found;
  logic [1:0]            grant_idx;
  logic [1:0]            search_idx;
  logic [ADDR_WIDTH-1:0] base_sel;
  logic                  buf_clear;

  assign p_req     = {p3_req, p2_req, p1_req, p0_req};
  assign p_addr[0] = p0_addr;
  assign p_addr[1] = p1_addr;
  assign p_addr[2] = p2_addr;
  assign p_addr[3] = p3_addr;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    p_ack_d     = '0;
    p_valid_d   = '0;
    for (int i = 0; i < 4; i++) p_q_d[i] = p_q_q[i];
    dl_full_d   = dl_full_q;
    dl_ovf_d    = dl_ovf_q;
    dl_addr_d   = dl_addr_q;
    dl_data_d   = dl_data_q;
    grant_found = 1'b0;
    grant_idx   = rr_q;
    search_idx  = rr_q;
    base_sel    = BASE_0;

    // Round-robin search starting at rr_q.
    for (int i = 0; i < 4; i++) begin
      search_idx = rr_q + 2'(i);
      if (!grant_found && p_req[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end

    unique case (grant_idx)
      2'd0: base_sel = BASE_0;
      2'd1: base_sel = BASE_1;
      2'd2: base_sel = BASE_2;
      2'd3: base_sel = BASE_3;
      default: base_sel = BASE_0;
    endcase

    buf_clear = (state_q == StWaitAck) && sdram_ack && we_q;

    unique case (state_q)
      StIdle: begin
        if (dl_full_q) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = dl_addr_q;
          data_d  = dl_data_q;
          state_d = StWaitAck;
        end else if (grant_found) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = base_sel + p_addr[grant_idx];  // wraps at ADDR_WIDTH
          data_d  = '0;
          owner_d = grant_idx;
          rr_d    = grant_idx + 2'd1;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = StIdle;
          end else begin
            p_ack_d[owner_q] = 1'b1;
            state_d          = StWaitValid;
          end
        end
      end
      StWaitValid: begin
        if (sdram_valid) begin
          p_valid_d[owner_q] = 1'b1;
          p_q_d[owner_q]     = sdram_q;
          state_d            = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A strobe coinciding with the write ack refills the slot being freed.
    if (buf_clear) dl_full_d = 1'b0;
    if (dl_wr) begin
      if (!dl_full_q || buf_clear) begin
        dl_full_d = 1'b1;
        dl_addr_d = dl_addr;
        dl_data_d = dl_data;
      end else begin
        dl_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rr_q      <= 2'd0;
      owner_q   <= 2'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      p_ack_q   <= '0;
      p_valid_q <= '0;
      for (int i = 0; i < 4; i++) p_q_q[i] <= '0;
      dl_full_q <= 1'b0;
      dl_ovf_q  <= 1'b0;
      dl_addr_q <= '0;
      dl_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      p_ack_q   <= p_ack_d;
      p_valid_q <= p_valid_d;
      for (int i = 0; i < 4; i++) p_q_q[i] <= p_q_d[i];
      dl_full_q <= dl_full_d;
      dl_ovf_q  <= dl_ovf_d;
      dl_addr_q <= dl_addr_d;
      dl_data_q <= dl_data_d;
    end
  end

  assign dl_ready    = !dl_full_q;
  assign dl_overflow = dl_ovf_q;
  assign sdram_req   = req_q;
  assign sdram_we    = we_q;
  assign sdram_addr  = addr_q;
  assign sdram_data  = data_q;
  assign p0_ack      = p_ack_q[0];
  assign p1_ack      = p_ack_q[1];
  assign p2_ack      = p_ack_q[2];
  assign p3_ack      = p_ack_q[3];
  assign p0_valid    = p_valid_q[0];
  assign p1_valid    = p_valid_q[1];
  assign p2_valid    = p_valid_q[2];
  assign p3_valid    = p_valid_q[3];
  assign p0_q        = p_q_q[0];
  assign p1_q        = p_q_q[1];
  assign p2_q        = p_q_q[2];
  assign p3_q        = p_q_q[3];

endmodule
